// File: rtl/vga_mem_arbiter.sv
// Arbitrates one external SRAM between line-buffer prefetch for the VGA scan-out
// and single-word writes from the drawing engine. Fetches take priority over writes.
module vga_mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcounter,
    input  logic [9:0]  vcounter,
    input  logic        wr_req,
    input  logic [14:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic [14:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        lb_we,
    output logic [5:0]  lb_addr,
    output logic [15:0] lb_data,
    output logic        busy,
    output logic        overrun
);

    localparam logic [14:0] FRAME_WORDS = 15'd19200;
    localparam logic [5:0]  LAST_IDX    = 6'd39;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_PULSE,
        S_WR_RECOVER
    } state_t;

    state_t      r_state;
    logic        r_fetch_pending;
    logic        r_overrun;
    logic [14:0] r_base;
    logic [5:0]  r_idx;
    logic        r_wr_ack;
    logic [14:0] r_sram_addr;
    logic [15:0] r_sram_wdata;
    logic        r_sram_we_n;
    logic        r_sram_oe_n;
    logic        r_lb_we;
    logic [5:0]  r_lb_addr;
    logic [15:0] r_lb_data;

    logic [9:0]  w_next_line;
    logic [14:0] w_line_ext;
    logic [14:0] w_new_base;
    logic        w_trigger;
    logic        w_in_fetch;
    logic        w_fetch_start;
    logic [14:0] w_start_addr;
    logic        w_wr_in_range;

    assign w_next_line = (vcounter == 10'd524) ? 10'd0 : vcounter + 10'd1;
    assign w_trigger   = (hcounter == 11'd640) && (w_next_line < 10'd480);

    // line*40 = line*32 + line*8
    assign w_line_ext  = {5'd0, w_next_line};
    assign w_new_base  = (w_line_ext << 5) + (w_line_ext << 3);

    // A new trigger inside a running fetch restarts it at word 0 of the new line.
    assign w_in_fetch    = (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
    assign w_fetch_start = (w_trigger && ((r_state == S_IDLE) || w_in_fetch)) ||
                           ((r_state == S_IDLE) && r_fetch_pending);
    assign w_start_addr  = w_trigger ? w_new_base : r_base;
    assign w_wr_in_range = (wr_addr < FRAME_WORDS);

    // NOTE: every state element here is a plain register, so all of it sits on the
    // async reset; there is no storage array that would need to be left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_fetch_pending <= 1'b0;
            r_overrun       <= 1'b0;
            r_base          <= '0;
            r_idx           <= '0;
            r_wr_ack        <= 1'b0;
            r_sram_addr     <= '0;
            r_sram_wdata    <= '0;
            r_sram_we_n     <= 1'b1;
            r_sram_oe_n     <= 1'b1;
            r_lb_we         <= 1'b0;
            r_lb_addr       <= '0;
            r_lb_data       <= '0;
        end else begin
            r_lb_we  <= 1'b0;
            r_wr_ack <= 1'b0;

            if (w_trigger) begin
                r_base          <= w_new_base;
                r_fetch_pending <= 1'b1;
                if (r_fetch_pending) begin
                    r_overrun <= 1'b1;
                end
            end

            // The word sampled at the end of RD_DATA is pushed to the line buffer next cycle.
            if (r_state == S_RD_DATA) begin
                r_lb_we   <= 1'b1;
                r_lb_addr <= r_idx;
                r_lb_data <= sram_rdata;
            end

            if (w_fetch_start) begin
                r_state     <= S_RD_ADDR;
                r_idx       <= '0;
                r_sram_addr <= w_start_addr;
                r_sram_oe_n <= 1'b0;
                r_sram_we_n <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (wr_req) begin
                            r_state      <= S_WR_PULSE;
                            r_wr_ack     <= 1'b1;
                            r_sram_addr  <= wr_addr;
                            r_sram_wdata <= wr_data;
                            r_sram_we_n  <= ~w_wr_in_range;
                            r_sram_oe_n  <= 1'b1;
                        end
                    end
                    S_RD_ADDR: begin
                        r_state <= S_RD_DATA;
                    end
                    S_RD_DATA: begin
                        if (r_idx == LAST_IDX) begin
                            r_state         <= S_IDLE;
                            r_fetch_pending <= 1'b0;
                            r_sram_oe_n     <= 1'b1;
                        end else begin
                            r_state     <= S_RD_ADDR;
                            r_idx       <= r_idx + 6'd1;
                            r_sram_addr <= r_base + {9'd0, r_idx + 6'd1};
                        end
                    end
                    S_WR_PULSE: begin
                        r_state     <= S_WR_RECOVER;
                        r_sram_we_n <= 1'b1;
                    end
                    S_WR_RECOVER: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_ack     = r_wr_ack;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign sram_we_n  = r_sram_we_n;
    assign sram_oe_n  = r_sram_oe_n;
    assign lb_we      = r_lb_we;
    assign lb_addr    = r_lb_addr;
    assign lb_data    = r_lb_data;
    assign busy       = r_fetch_pending;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: trigger-decode vector table plus hand-written
// sequences for full fetch, frame wrap, collisions, out-of-range writes and reset.
`timescale 1ns/1ps
module tb_vga_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcounter = '0;
    logic [9:0]  vcounter = '0;
    logic        wr_req = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic [14:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        lb_we;
    logic [5:0]  lb_addr;
    logic [15:0] lb_data;
    logic        busy;
    logic        overrun;

    vga_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .hcounter   (hcounter),
        .vcounter   (vcounter),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_data    (lb_data),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] exp_word(input int a);
        logic [15:0] v;
        v = 16'(a) * 16'd37;
        return v ^ 16'h5A5A;
    endfunction

    // SRAM model: asynchronous read while oe_n is low, write on the clock edge.
    logic [15:0] mem [0:32767];
    initial for (int i = 0; i < 32768; i++) mem[i] = exp_word(i);
    assign sram_rdata = sram_oe_n ? 16'h0000 : mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_wdata;

    // Event log sampled on the falling edge, away from the active edge.
    int          lb_cyc [$];
    int          lb_a   [$];
    logic [15:0] lb_d   [$];
    int          we_cnt, we_cyc, ack_cnt, ack_cyc;
    logic [14:0] we_addr;
    logic [15:0] we_data;
    bit          busy_seen;

    always @(negedge clk) begin
        if (lb_we) begin
            lb_cyc.push_back(cyc);
            lb_a.push_back(int'(lb_addr));
            lb_d.push_back(lb_data);
        end
        if (!sram_we_n) begin
            we_cnt++;
            we_cyc  = cyc;
            we_addr = sram_addr;
            we_data = sram_wdata;
        end
        if (wr_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (busy) busy_seen = 1'b1;
    end

    task automatic clear_log();
        lb_cyc.delete();
        lb_a.delete();
        lb_d.delete();
        we_cnt = 0; we_cyc = -1; ack_cnt = 0; ack_cyc = -1;
        we_addr = '0; we_data = '0; busy_seen = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        hcounter = '0; vcounter = '0; wr_req = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_log();
    endtask

    // The writer drops wr_req right after the cycle in which it sees wr_ack.
    task automatic run_cycles(input int n);
        bit acked;
        for (int i = 0; i < n; i++) begin
            acked = 1'b0;
            @(negedge clk);
            if (wr_ack) acked = 1'b1;
            @(posedge clk); #1;
            if (acked) wr_req = 1'b0;
        end
    endtask

    task automatic check_fetch(input string tag, input int base, input int first_cyc);
        check({tag, "_count"}, lb_cyc.size(), 40);
        if (lb_cyc.size() == 40) begin
            for (int k = 0; k < 40; k++) begin
                check($sformatf("%s_addr%0d", tag, k), lb_a[k], k);
                check($sformatf("%s_data%0d", tag, k), lb_d[k], exp_word(base + k));
                check($sformatf("%s_cyc%0d", tag, k), lb_cyc[k], first_cyc + 2 * k);
            end
        end
    endtask

    typedef struct {
        logic [9:0]  v;
        logic [10:0] h;
        logic        exp_busy;
        logic        exp_oe_n;
        logic [14:0] exp_addr;
    } vec_t;

    vec_t vecs [8];
    int   t0;

    initial begin
        vecs[0] = '{10'd9,   11'd640, 1'b1, 1'b0, 15'd400};
        vecs[1] = '{10'd524, 11'd640, 1'b1, 1'b0, 15'd0};
        vecs[2] = '{10'd0,   11'd640, 1'b1, 1'b0, 15'd40};
        vecs[3] = '{10'd478, 11'd640, 1'b1, 1'b0, 15'd19160};
        vecs[4] = '{10'd479, 11'd640, 1'b0, 1'b1, 15'd0};
        vecs[5] = '{10'd523, 11'd640, 1'b0, 1'b1, 15'd0};
        vecs[6] = '{10'd9,   11'd639, 1'b0, 1'b1, 15'd0};
        vecs[7] = '{10'd9,   11'd641, 1'b0, 1'b1, 15'd0};

        // Reset state
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_oe_n", sram_oe_n, 1'b1);
        check("rst_addr", sram_addr, 15'd0);
        check("rst_lb_we", lb_we, 1'b0);
        check("rst_ack", wr_ack, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Trigger decode: the cycle after the trigger must be RD_ADDR at line*40.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            vcounter = vecs[i].v; hcounter = vecs[i].h;
            @(posedge clk); #1;
            vcounter = '0; hcounter = '0;
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_oe_n", i), sram_oe_n, vecs[i].exp_oe_n);
            check($sformatf("vec%0d_addr", i), sram_addr, vecs[i].exp_addr);
        end

        // Full fetch of line 10 (base 400); word k lands at T+3+2k.
        do_reset();
        t0 = cyc; vcounter = 10'd9; hcounter = 11'd640;
        @(posedge clk); #1;
        hcounter = 11'd641;
        run_cycles(100);
        check_fetch("fetch", 400, t0 + 3);
        check("fetch_we_cnt", we_cnt, 0);
        check("fetch_busy_end", busy, 1'b0);

        // Frame wrap to line 0, then last visible line with no follow-on fetch.
        do_reset();
        t0 = cyc; vcounter = 10'd524; hcounter = 11'd640;
        @(posedge clk); #1;
        hcounter = 11'd0;
        run_cycles(100);
        check_fetch("wrap", 0, t0 + 3);
        do_reset();
        vcounter = 10'd479; hcounter = 11'd640;
        @(posedge clk); #1;
        hcounter = 11'd0;
        run_cycles(100);
        check("nofetch_count", lb_cyc.size(), 0);
        check("nofetch_busy", busy_seen, 1'b0);

        // Collision: write request in the trigger cycle waits for the whole fetch.
        // Fetch leaves RD_DATA at T+80, passes IDLE at T+81, WR_PULSE at T+82.
        do_reset();
        t0 = cyc; vcounter = 10'd9; hcounter = 11'd640;
        wr_req = 1'b1; wr_addr = 15'd200; wr_data = 16'h1234;
        @(posedge clk); #1;
        hcounter = 11'd0;
        run_cycles(120);
        check_fetch("coll", 400, t0 + 3);
        check("coll_ack_cnt", ack_cnt, 1);
        check("coll_ack_cyc", ack_cyc, t0 + 82);
        check("coll_we_cnt", we_cnt, 1);
        check("coll_we_cyc", we_cyc, t0 + 82);
        check("coll_we_addr", we_addr, 15'd200);
        check("coll_we_data", we_data, 16'h1234);

        // Write then trigger one cycle later: write finishes, fetch starts 2 cycles late.
        do_reset();
        wr_req = 1'b1; wr_addr = 15'd100; wr_data = 16'hA5A5;
        @(posedge clk); #1;
        t0 = cyc; vcounter = 10'd19; hcounter = 11'd640;
        run_cycles(1);
        hcounter = 11'd0;
        run_cycles(100);
        check("wt_ack_cnt", ack_cnt, 1);
        check("wt_we_cnt", we_cnt, 1);
        check("wt_we_cyc", we_cyc, t0);
        check("wt_we_addr", we_addr, 15'd100);
        check("wt_we_data", we_data, 16'hA5A5);
        check_fetch("wt", 800, t0 + 5);
        check("wt_mem100", mem[100], 16'hA5A5);

        // Out-of-range write is acknowledged once but never strobes the SRAM.
        do_reset();
        wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 16'hFFFF;
        run_cycles(10);
        check("oor_ack_cnt", ack_cnt, 1);
        check("oor_we_cnt", we_cnt, 0);
        check("oor_wr_req", wr_req, 1'b0);

        // Reset at word 20 of a fetch, then a forced double trigger.
        do_reset();
        vcounter = 10'd9; hcounter = 11'd640;
        @(posedge clk); #1;
        hcounter = 11'd0;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk); #1;
                if (lb_cyc.size() == 21) hit = 1'b1;
            end
            check("rstmid_reached_w20", hit, 1'b1);
        end
        reset = 1'b0;
        #1;
        check("rstmid_lb_we", lb_we, 1'b0);
        check("rstmid_lb_addr", lb_addr, 6'd0);
        check("rstmid_lb_data", lb_data, 16'd0);
        check("rstmid_oe_n", sram_oe_n, 1'b1);
        check("rstmid_we_n", sram_we_n, 1'b1);
        check("rstmid_addr", sram_addr, 15'd0);
        check("rstmid_wdata", sram_wdata, 16'd0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ack", wr_ack, 1'b0);
        check("rstmid_overrun", overrun, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        clear_log();
        run_cycles(100);
        check("rstmid_nofetch", lb_cyc.size(), 0);
        check("rstmid_nobusy", busy_seen, 1'b0);

        t0 = cyc; vcounter = 10'd9; hcounter = 11'd640;
        @(posedge clk); #1;
        vcounter = 10'd19;
        @(posedge clk); #1;
        hcounter = 11'd0;
        @(negedge clk);
        check("dbl_overrun", overrun, 1'b1);
        run_cycles(100);
        check_fetch("dbl", 800, t0 + 4);
        check("dbl_overrun_sticky", overrun, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
